// File: rtl/sorted_ram_writer.sv
// Inserts one value per start episode into a registered-read RAM, shifting larger entries up so
// entries 0..count-1 stay ascending; done follows 2+2*compares cycles after accept (1 cycle if full).
module sorted_ram_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_INS,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              armed;
    logic              accept;
    logic              is_full;
    logic              is_empty;
    logic              shift;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count_q;
    logic              done_q;
    logic              full_q;

    // A start level held across reset must drop before it can trigger an insert.
    assign accept   = (state == S_IDLE) && start && armed;
    assign is_full  = (count_q == FULL_COUNT);
    assign is_empty = (count_q == '0);
    assign shift    = (state == S_CMP) && (rd_data > din);

    assign count = count_q;
    assign done  = done_q;
    assign full  = full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_full) begin
                        state_nxt = S_DONE;
                    end else if (is_empty) begin
                        state_nxt = S_INS;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD:  state_nxt = S_CMP;
            S_CMP: begin
                if (shift && (idx != '0)) begin
                    state_nxt = S_RD;
                end else begin
                    state_nxt = S_INS;
                end
            end
            S_INS: state_nxt = S_DONE;
            S_DONE: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            S_RD: rd_addr = idx;
            S_CMP: begin
                // Equal entries stay put, so a duplicate lands above its twins.
                if (shift) begin
                    wr_en   = 1'b1;
                    wr_addr = idx + 1'b1;
                    wr_data = rd_data;
                end
            end
            S_INS: begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din <= '0;
            idx <= '0;
            ptr <= '0;
        end else if (accept) begin
            din <= data_in;
            idx <= count_q[ADDR_W-1:0] - 1'b1;
            ptr <= '0;
        end else if (state == S_CMP) begin
            if (shift) begin
                if (idx == '0) begin
                    ptr <= '0;
                end else begin
                    idx <= idx - 1'b1;
                end
            end else begin
                ptr <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed   <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            if (accept) begin
                armed <= 1'b0;
            end else if (!start) begin
                armed <= 1'b1;
            end

            if (state == S_INS) begin
                count_q <= count_q + 1'b1;
            end

            if (state_nxt == S_DONE) begin
                done_q <= 1'b1;
            end else if (accept) begin
                done_q <= 1'b0;
            end

            if (accept) begin
                full_q <= is_full;
            end
        end
    end

endmodule

// File: tb/tb_sorted_ram_writer.sv
// Bench for sorted_ram_writer: a sorted-queue model predicts every RAM write, latency, count and full.
module tb_sorted_ram_writer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              full;

    sorted_ram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .count   (count),
        .done    (done),
        .full    (full)
    );

    always #5 clk = ~clk;

    // Registered-read RAM shared with the searcher.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  model[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next predicted write.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", int'(wr_addr), e.addr);
                check("write_data", int'(wr_data), e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic hold_start);
        reset = 1'b1;
        start = hold_start;
        tick();
        tick();
        check("rst_count", int'(count), 0);
        check("rst_done", int'(done), 0);
        check("rst_full", int'(full), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        exp_q.delete();
        model.delete();
        reset = 1'b0;
    endtask

    task automatic check_ram();
        for (int j = 0; j < model.size(); j++) begin
            check($sformatf("ram[%0d]", j), int'(mem[j]), model[j]);
        end
    endtask

    task automatic do_insert(input int v, input bit change_data);
        int c, k, pos, lat, n;
        wr_t w;
        start = 1'b0;
        tick();
        tick();
        c = model.size();
        k = 0;
        foreach (model[j]) if (model[j] > v) k++;
        pos = c - k;
        if (c == DEPTH) begin
            lat = 1;
        end else begin
            for (int j = c - 1; j >= pos; j--) begin
                w.addr = j + 1;
                w.data = model[j];
                exp_q.push_back(w);
            end
            w.addr = pos;
            w.data = v;
            exp_q.push_back(w);
            lat = 2 + 2 * ((k < c) ? k + 1 : k);
        end
        data_in = v[DATA_W-1:0];
        start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (change_data && n == 2) data_in = 8'd99;
        end while (!done && n < 200);
        check($sformatf("latency_v%0d_c%0d", v, c), n, lat);
        check("full_flag", int'(full), (c == DEPTH) ? 1 : 0);
        if (c != DEPTH) model.insert(pos, v);
        check("count", int'(count), model.size());
    endtask

    initial begin
        do_reset(1'b0);

        do_insert(50, 1'b0);
        check_ram();

        do_reset(1'b0);
        do_insert(30, 1'b0);
        do_insert(10, 1'b0);
        do_insert(20, 1'b0);
        check_ram();
        do_insert(20, 1'b0);
        do_insert(255, 1'b0);
        check_ram();

        do_reset(1'b0);
        for (int v = 255; v >= 224; v--) do_insert(v, 1'b0);
        check_ram();
        do_insert(0, 1'b0);
        check("full_count", int'(count), 32);
        do_reset(1'b0);

        do_insert(5, 1'b1);
        check_ram();

        // Abandon an insert mid-shift with start still high.
        do_insert(100, 1'b0);
        do_insert(200, 1'b0);
        do_insert(150, 1'b0);
        start = 1'b0;
        tick();
        tick();
        begin
            wr_t w;
            for (int j = 3; j >= 0; j--) begin
                w.addr = j + 1;
                w.data = model[j];
                exp_q.push_back(w);
            end
        end
        data_in = 8'd1;
        start = 1'b1;
        tick();
        tick();
        tick();
        do_reset(1'b1);
        for (int j = 0; j < 5; j++) tick();
        check("post_rst_count", int'(count), 0);
        check("post_rst_done", int'(done), 0);
        do_insert(7, 1'b0);
        check_ram();

        do_reset(1'b0);
        for (int t = 0; t < 45; t++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 43)) : int'($urandom_range(0, 255));
            do_insert(v, $urandom_range(0, 1) == 1);
        end
        check_ram();

        start = 1'b0;
        tick();
        tick();
        check("wr_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
